pc_branch_sequencer: RTL and testbench

Program-counter register stage for the MOS 6502 core. Holds the 16-bit PC and updates it by load, increment, or relative branch. A taken branch adds a signed 8-bit offset to PCL in one cycle. When the result crosses a page, a second fix-up cycle corrects PCH, which reproduces the 6502 page-crossing penalty. It sits directly upstream of the PC high-byte incrementer and the address-bus mux, and it supplies the current PC and the PCL-increment carry.

---
 rtl/pc_branch_sequencer.sv | 70 +++++++
 tb/tb_pc_branch_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_branch_sequencer.sv
// 6502 program-counter stage: load / increment / relative branch, with an extra
// PCH fix-up cycle when a branch lands on a different page.
module pc_branch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcLoad_EN,
    input  logic [15:0] pcLoad_IN,
    input  logic        pcInc_EN,
    input  logic        branch_EN,
    input  logic [7:0]  branchOffset_IN,
    output logic [15:0] pc_OUT,
    output logic        pcLowCarry_OUT,
    output logic        busy_OUT,
    output logic        pageCross_OUT
);

    typedef enum logic {IDLE, FIX} state_t;

    state_t      state;
    logic        dir_up;
    logic [8:0]  br_sum;
    logic        br_cross;

    // Carry out of PCL decides crossing; its meaning flips with the offset sign.
    always_comb begin
        br_sum   = {1'b0, pc_OUT[7:0]} + {1'b0, branchOffset_IN};
        br_cross = branchOffset_IN[7] ? ~br_sum[8] : br_sum[8];
    end

    assign pcLowCarry_OUT = pcInc_EN && (state == IDLE) && (pc_OUT[7:0] == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc_OUT        <= RESET_PC;
            busy_OUT      <= 1'b0;
            pageCross_OUT <= 1'b0;
            dir_up        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pcLoad_EN) begin
                        pc_OUT <= pcLoad_IN;
                    end else if (branch_EN) begin
                        pc_OUT[7:0] <= br_sum[7:0];
                        if (br_cross) begin
                            dir_up        <= ~branchOffset_IN[7];
                            state         <= FIX;
                            busy_OUT      <= 1'b1;
                            pageCross_OUT <= 1'b1;
                        end
                    end else if (pcInc_EN) begin
                        pc_OUT <= pc_OUT + 16'd1;
                    end
                end
                FIX: begin
                    // Commands are dropped here; the requester holds them until busy falls.
                    pc_OUT[15:8]  <= dir_up ? pc_OUT[15:8] + 8'd1 : pc_OUT[15:8] - 8'd1;
                    state         <= IDLE;
                    busy_OUT      <= 1'b0;
                    pageCross_OUT <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Randomized + directed bench for pc_branch_sequencer with a scoreboard monitor.
module tb_pc_branch_sequencer;

    localparam logic [15:0] RST_PC = 16'hFFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcLoad_EN;
    logic [15:0] pcLoad_IN;
    logic        pcInc_EN;
    logic        branch_EN;
    logic [7:0]  branchOffset_IN;
    logic [15:0] pc_OUT;
    logic        pcLowCarry_OUT;
    logic        busy_OUT;
    logic        pageCross_OUT;

    pc_branch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .pcLoad_EN(pcLoad_EN), .pcLoad_IN(pcLoad_IN),
        .pcInc_EN(pcInc_EN), .branch_EN(branch_EN),
        .branchOffset_IN(branchOffset_IN),
        .pc_OUT(pc_OUT), .pcLowCarry_OUT(pcLowCarry_OUT),
        .busy_OUT(busy_OUT), .pageCross_OUT(pageCross_OUT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        busy;
        logic        pcross;
    } exp_t;

    exp_t exp_q[$];
    bit   carry_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural PC plus a pending branch target.
    logic [15:0] m_pc;
    logic [15:0] m_tgt;
    bit          m_fix   = 0;
    bit          m_known = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc(input bit r, input bit ld, input logic [15:0] lv,
                       input bit inc, input bit br, input logic [7:0] off);
        int   t;
        exp_t e;
        rst = r; pcLoad_EN = ld; pcLoad_IN = lv;
        pcInc_EN = inc; branch_EN = br; branchOffset_IN = off;
        if (m_known)
            carry_q.push_back(inc && !m_fix && (m_pc[7:0] == 8'hFF));
        if (r) begin
            m_pc = RST_PC; m_fix = 0; m_known = 1;
        end else if (m_fix) begin
            m_pc = m_tgt; m_fix = 0;
        end else if (ld) begin
            m_pc = lv;
        end else if (br) begin
            t = (int'(m_pc) + int'($signed(off))) & 32'hFFFF;
            if (t[15:8] != m_pc[15:8]) begin
                m_tgt = t[15:0];
                m_pc  = {m_pc[15:8], t[7:0]};
                m_fix = 1;
            end else begin
                m_pc = t[15:0];
            end
        end else if (inc) begin
            m_pc = m_pc + 16'd1;
        end
        e.pc = m_pc; e.busy = m_fix; e.pcross = m_fix;
        if (m_known) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 16'h0, 0, 0, 8'h00);
    endtask

    // Output monitor: one expected entry per driven cycle, checked after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc", pc_OUT, e.pc);
                chk("busy", {15'd0, busy_OUT}, {15'd0, e.busy});
                chk("pageCross", {15'd0, pageCross_OUT}, {15'd0, e.pcross});
            end
        end
    end

    // Combinational carry is sampled late in the cycle in which inputs are driven.
    initial begin
        bit c;
        forever begin
            @(negedge clk);
            #3;
            if (carry_q.size() != 0) begin
                c = carry_q.pop_front();
                chk("pcLowCarry", {15'd0, pcLowCarry_OUT}, {15'd0, c});
            end
        end
    end

    initial begin
        rst = 1; pcLoad_EN = 0; pcLoad_IN = 0; pcInc_EN = 0;
        branch_EN = 0; branchOffset_IN = 0;
        @(negedge clk);
        // reset with all enables high
        cyc(1, 1, 16'h1234, 1, 1, 8'h20);
        cyc(1, 1, 16'h1234, 1, 1, 8'h20);
        idle();
        // up-crossing
        cyc(0, 1, 16'h80F0, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 0, 1, 8'h20);
        idle(); idle();
        // down-crossings
        cyc(0, 1, 16'h8010, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 0, 1, 8'hE0);
        idle(); idle();
        cyc(0, 1, 16'h0005, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 0, 1, 8'hF0);
        idle(); idle();
        // same-page branches
        cyc(0, 1, 16'h8000, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 0, 1, 8'h05);
        cyc(0, 1, 16'h8010, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 0, 1, 8'hFE);
        cyc(0, 0, 16'h0, 0, 1, 8'h00);
        // increments across PCL and full wrap
        cyc(0, 1, 16'h80FF, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 1, 0, 8'h00);
        cyc(0, 1, 16'hFFFF, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 1, 0, 8'h00);
        // load beats branch
        cyc(0, 1, 16'h4000, 0, 1, 8'h7F);
        // commands during FIX are dropped
        cyc(0, 1, 16'h80F0, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 0, 1, 8'h20);
        cyc(0, 1, 16'h1234, 1, 1, 8'h40);
        idle();
        // reset during FIX discards the correction
        cyc(0, 1, 16'h80F0, 0, 0, 8'h00);
        cyc(0, 0, 16'h0, 0, 1, 8'h20);
        cyc(1, 0, 16'h0, 0, 0, 8'h00);
        idle(); idle();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) == 0), 16'($urandom),
                ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 2) == 0), 8'($urandom));
        end
        idle(); idle();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
